// File: rtl/key_pkg.sv
// Shared state encodings and counter-width helper for the key_ctrl button controller.
package key_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PRESS_FILT = 2'd1,
        HOLD       = 2'd2,
        REL_FILT   = 2'd3
    } key_state_e;

    // Bits needed to hold 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        if (n <= 2) begin
            return 1;
        end
        return $clog2(n);
    endfunction

endpackage

// File: rtl/key_ctrl_edge_det.sv
// edge_det: one-cycle rise/fall flags on an already synchronised level.
module edge_det (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic i_btn,
    output logic posedge_flag,
    output logic negedge_flag
);

    logic btn_d;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            btn_d <= 1'b0;
        end else begin
            btn_d <= i_btn;
        end
    end

    assign posedge_flag = i_btn & ~btn_d;
    assign negedge_flag = ~i_btn & btn_d;

endmodule

// File: rtl/key_ctrl.sv
// Push-button debounce and press/release/long-press event controller.
// Define KEY_REPEAT_EN to enable auto-repeat o_press pulses after o_long.
module key_ctrl
    import key_pkg::*;
#(
    parameter int unsigned DEB_CNT  = 20,
`ifdef KEY_REPEAT_EN
    parameter int unsigned REP_CNT  = 25,
`endif
    parameter int unsigned LONG_CNT = 100
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic i_btn,
    output logic o_level,
    output logic o_press,
    output logic o_release,
    output logic o_long
);

    localparam int unsigned DEB_W  = cnt_width(DEB_CNT);
    localparam int unsigned HOLD_W = cnt_width(LONG_CNT);
`ifdef KEY_REPEAT_EN
    localparam int unsigned REP_W  = cnt_width(REP_CNT);
`endif

    logic s1;
    logic s2;
    logic pos_flag;
    logic neg_flag;

    key_state_e        state;
    key_state_e        state_nxt;
    logic [DEB_W-1:0]  deb_cnt;
    logic [DEB_W-1:0]  deb_nxt;
    logic [HOLD_W-1:0] hold_cnt;
    logic [HOLD_W-1:0] hold_nxt;
    logic              long_done;
    logic              long_done_nxt;
    logic              level_nxt;
    logic              press_nxt;
    logic              release_nxt;
    logic              long_nxt;
`ifdef KEY_REPEAT_EN
    logic [REP_W-1:0]  rep_cnt;
    logic [REP_W-1:0]  rep_nxt;
`endif

    // Two-flop synchroniser for the asynchronous button input.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= i_btn;
            s2 <= s1;
        end
    end

    edge_det u_edge_det (
        .sys_clk      (sys_clk),
        .sys_rst_n    (sys_rst_n),
        .i_btn        (s2),
        .posedge_flag (pos_flag),
        .negedge_flag (neg_flag)
    );

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state     <= IDLE;
            deb_cnt   <= '0;
            hold_cnt  <= '0;
            long_done <= 1'b0;
            o_level   <= 1'b0;
            o_press   <= 1'b0;
            o_release <= 1'b0;
            o_long    <= 1'b0;
`ifdef KEY_REPEAT_EN
            rep_cnt   <= '0;
`endif
        end else begin
            state     <= state_nxt;
            deb_cnt   <= deb_nxt;
            hold_cnt  <= hold_nxt;
            long_done <= long_done_nxt;
            o_level   <= level_nxt;
            o_press   <= press_nxt;
            o_release <= release_nxt;
            o_long    <= long_nxt;
`ifdef KEY_REPEAT_EN
            rep_cnt   <= rep_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt     = state;
        deb_nxt       = deb_cnt;
        hold_nxt      = hold_cnt;
        long_done_nxt = long_done;
        level_nxt     = o_level;
        press_nxt     = 1'b0;
        release_nxt   = 1'b0;
        long_nxt      = 1'b0;
`ifdef KEY_REPEAT_EN
        rep_nxt       = rep_cnt;
`endif

        case (state)
            IDLE: begin
                if (pos_flag) begin
                    state_nxt = PRESS_FILT;
                    deb_nxt   = '0;
                end
            end

            PRESS_FILT: begin
                if (!s2) begin
                    state_nxt = IDLE;
                end else if (deb_cnt == DEB_W'(DEB_CNT - 1)) begin
                    state_nxt     = HOLD;
                    press_nxt     = 1'b1;
                    level_nxt     = 1'b1;
                    hold_nxt      = '0;
                    long_done_nxt = 1'b0;
                end else begin
                    deb_nxt = deb_cnt + DEB_W'(1);
                end
            end

            HOLD: begin
                if (hold_cnt != HOLD_W'(LONG_CNT - 1)) begin
                    hold_nxt = hold_cnt + HOLD_W'(1);
                end
                // Long-press takes priority; a coincident repeat waits a cycle.
                if (hold_cnt == HOLD_W'(LONG_CNT - 1) && !long_done) begin
                    long_nxt      = 1'b1;
                    long_done_nxt = 1'b1;
`ifdef KEY_REPEAT_EN
                    rep_nxt       = '0;
                end else if (long_done) begin
                    if (rep_cnt == REP_W'(REP_CNT - 1)) begin
                        press_nxt = 1'b1;
                        rep_nxt   = '0;
                    end else begin
                        rep_nxt = rep_cnt + REP_W'(1);
                    end
`endif
                end
                if (neg_flag) begin
                    state_nxt = REL_FILT;
                    deb_nxt   = '0;
                end
            end

            REL_FILT: begin
                if (s2) begin
                    state_nxt = HOLD;
                end else if (deb_cnt == DEB_W'(DEB_CNT - 1)) begin
                    state_nxt   = IDLE;
                    release_nxt = 1'b1;
                    level_nxt   = 1'b0;
                end else begin
                    deb_nxt = deb_cnt + DEB_W'(1);
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_key_ctrl.sv
// Directed bench for key_ctrl: table of pulse lengths plus bounce, glitch and reset sequences.
module tb_key_ctrl;

    localparam int unsigned DEB  = 4;
    localparam int unsigned LONG = 8;
    localparam int unsigned REPC = 5;
`ifdef KEY_REPEAT_EN
    localparam bit REP_ON = 1'b1;
`else
    localparam bit REP_ON = 1'b0;
`endif

    logic sys_clk   = 1'b0;
    logic sys_rst_n = 1'b0;
    logic i_btn     = 1'b0;
    logic o_level;
    logic o_press;
    logic o_release;
    logic o_long;

    key_ctrl #(
        .DEB_CNT  (DEB),
`ifdef KEY_REPEAT_EN
        .REP_CNT  (REPC),
`endif
        .LONG_CNT (LONG)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .i_btn     (i_btn),
        .o_level   (o_level),
        .o_press   (o_press),
        .o_release (o_release),
        .o_long    (o_long)
    );

    always #5 sys_clk = ~sys_clk;

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    // Event log: edge number of every output pulse, sampled mid-cycle.
    int press_q[$];
    int long_q[$];
    int rel_q[$];
    int multi_hot = 0;
    always @(negedge sys_clk) begin
        if (o_press)   press_q.push_back(cyc);
        if (o_long)    long_q.push_back(cyc);
        if (o_release) rel_q.push_back(cyc);
        if (int'(o_press) + int'(o_release) + int'(o_long) > 1) multi_hot++;
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic clear_log();
        press_q.delete();
        long_q.delete();
        rel_q.delete();
    endtask

    // Hold i_btn high for len edges starting at edge k; it falls before edge f.
    task automatic pulse_run(input int len, output int k, output int f, output int lvl_mid);
        @(negedge sys_clk);
        k = cyc + 1;
        i_btn = 1'b1;
        repeat (len) @(negedge sys_clk);
        lvl_mid = int'(o_level);
        i_btn = 1'b0;
        f = cyc + 1;
        repeat (30) @(negedge sys_clk);
    endtask

    typedef struct {
        int len;
        int n_press;
        int press_off;
        int n_long;
        int long_off;
        int n_rel;
        int rel_off;
        int lvl_mid;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int k;
        int f;
        int k2;
        int lvl;

        // len, presses, press@k+, longs, long@k+, releases, release@f+, level before fall
        vecs[0] = '{2,  0, 0, 0, 0, 0, 0, 0};
        vecs[1] = '{3,  0, 0, 0, 0, 0, 0, 0};
        vecs[2] = '{4,  0, 0, 0, 0, 0, 0, 0};
        vecs[3] = '{5,  1, 6, 0, 0, 1, 6, 0};
        vecs[4] = '{10, 1, 6, 0, 0, 1, 6, 1};
        vecs[5] = '{14, 1, 6, 1, 14, 1, 6, 1};
        vecs[6] = '{30, REP_ON ? 4 : 1, 6, 1, 14, 1, 6, 1};
        vecs[7] = '{40, REP_ON ? 6 : 1, 6, 1, 14, 1, 6, 1};

        repeat (3) @(negedge sys_clk);
        check("reset o_level",   int'(o_level),   0);
        check("reset o_press",   int'(o_press),   0);
        check("reset o_release", int'(o_release), 0);
        check("reset o_long",    int'(o_long),    0);
        check("reset state",     int'(dut.state), 0);
        sys_rst_n = 1'b1;
        repeat (3) @(negedge sys_clk);

        for (int i = 0; i < 8; i++) begin
            clear_log();
            pulse_run(vecs[i].len, k, f, lvl);
            check($sformatf("v%0d press_n", i), press_q.size(), vecs[i].n_press);
            if (vecs[i].n_press > 0 && press_q.size() > 0)
                check($sformatf("v%0d press_at", i), press_q[0] - k, vecs[i].press_off);
            for (int j = 1; j < press_q.size(); j++)
                check($sformatf("v%0d repeat%0d_at", i, j), press_q[j] - k, 14 + int'(REPC) * j);
            check($sformatf("v%0d long_n", i), long_q.size(), vecs[i].n_long);
            if (vecs[i].n_long > 0 && long_q.size() > 0)
                check($sformatf("v%0d long_at", i), long_q[0] - k, vecs[i].long_off);
            check($sformatf("v%0d rel_n", i), rel_q.size(), vecs[i].n_rel);
            if (vecs[i].n_rel > 0 && rel_q.size() > 0)
                check($sformatf("v%0d rel_at", i), rel_q[0] - f, vecs[i].rel_off);
            check($sformatf("v%0d level_mid", i), lvl, vecs[i].lvl_mid);
            check($sformatf("v%0d level_end", i), int'(o_level), 0);
        end

        // Bounce: high 2, low 1, then steady high; only the second rise counts.
        clear_log();
        @(negedge sys_clk);
        i_btn = 1'b1;
        repeat (2) @(negedge sys_clk);
        i_btn = 1'b0;
        @(negedge sys_clk);
        k2 = cyc + 1;
        i_btn = 1'b1;
        repeat (10) @(negedge sys_clk);
        i_btn = 1'b0;
        f = cyc + 1;
        repeat (30) @(negedge sys_clk);
        check("bounce press_n", press_q.size(), 1);
        if (press_q.size() > 0) check("bounce press_at", press_q[0] - k2, 6);
        check("bounce long_n", long_q.size(), 0);
        check("bounce rel_n", rel_q.size(), 1);
        if (rel_q.size() > 0) check("bounce rel_at", rel_q[0] - f, 6);

        // Release glitch in HOLD: low 2 edges then high again; long press is delayed, not lost.
        clear_log();
        @(negedge sys_clk);
        k = cyc + 1;
        i_btn = 1'b1;
        repeat (8) @(negedge sys_clk);
        i_btn = 1'b0;
        repeat (2) @(negedge sys_clk);
        i_btn = 1'b1;
        repeat (20) @(negedge sys_clk);
        i_btn = 1'b0;
        f = cyc + 1;
        repeat (30) @(negedge sys_clk);
        check("glitch press_n", press_q.size(), REP_ON ? 4 : 1);
        if (press_q.size() > 0) check("glitch press_at", press_q[0] - k, 6);
        check("glitch long_n", long_q.size(), 1);
        if (long_q.size() > 0) check("glitch long_at", long_q[0] - k, 16);
        check("glitch rel_n", rel_q.size(), 1);
        if (rel_q.size() > 0) check("glitch rel_at", rel_q[0] - f, 6);

        // Reset while filtering a press.
        @(negedge sys_clk);
        i_btn = 1'b1;
        repeat (4) @(negedge sys_clk);
        check("rst_pf pre_state", int'(dut.state), 1);
        sys_rst_n = 1'b0;
        #1;
        check("rst_pf state", int'(dut.state), 0);
        check("rst_pf level", int'(o_level), 0);
        i_btn = 1'b0;
        repeat (3) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        clear_log();
        repeat (20) @(negedge sys_clk);
        check("rst_pf after press_n", press_q.size(), 0);
        check("rst_pf after rel_n", rel_q.size(), 0);

        // Reset while holding: level drops at once, no release pulse follows.
        @(negedge sys_clk);
        i_btn = 1'b1;
        repeat (9) @(negedge sys_clk);
        check("rst_hold pre_level", int'(o_level), 1);
        sys_rst_n = 1'b0;
        #1;
        check("rst_hold level", int'(o_level), 0);
        check("rst_hold press", int'(o_press), 0);
        check("rst_hold state", int'(dut.state), 0);
        i_btn = 1'b0;
        clear_log();
        repeat (3) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        repeat (20) @(negedge sys_clk);
        check("rst_hold after press_n", press_q.size(), 0);
        check("rst_hold after rel_n", rel_q.size(), 0);
        check("rst_hold after long_n", long_q.size(), 0);

        check("one pulse per cycle", multi_hot, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
